store_data_aligner: RTL and testbench

- Write-side counterpart of immediate/load extension in the MIPS datapath.
- Takes a 32-bit register value plus a store size (SB/SH/SW) and narrows it onto a word-aligned memory write.
- Produces byte-replicated write data and per-byte write enables.
- Buffers stores in a small FIFO and drives data memory through a req/ack handshake; sits between the MEM stage and the data-memory port.

---
 rtl/store_data_aligner_pkg.sv | 31 +++
 rtl/store_data_aligner_lane_encoder.sv | 33 +++
 rtl/store_data_aligner.sv | 110 +++++++++++
 tb/tb_store_data_aligner.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/store_data_aligner_pkg.sv
// Shared store-path definitions: size encodings, lane struct and alignment check.
// Used by the lane encoder and the store buffer top.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  localparam int DATA_W = 32;
  localparam int WE_W   = DATA_W / 8;
  localparam int LANE_W = DATA_W + WE_W;

  typedef struct packed {
    logic [WE_W-1:0]   we;
    logic [DATA_W-1:0] wdata;
  } lane_t;

  // Size 11 is never legal; halves need even addresses, words need 4-byte alignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_data_aligner_lane_encoder.sv
// Combinational little-endian lane encoder: replicates store data across lanes
// and builds byte enables from size and the low address bits.
module store_lane_encoder
  import store_pkg::*;
(
  input  logic [1:0]        i_size,
  input  logic [1:0]        i_addr_lo,
  input  logic [DATA_W-1:0] i_data,
  output logic [WE_W-1:0]   o_we,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_misaligned
);

  always_comb begin
    o_misaligned = is_misaligned(i_size, i_addr_lo);
    o_we         = '0;
    o_wdata      = i_data;
    case (i_size)
      SZ_BYTE: begin
        o_we    = WE_W'(4'b0001) << i_addr_lo;
        o_wdata = {4{i_data[7:0]}};
      end
      SZ_HALF: begin
        o_we    = WE_W'(4'b0011) << i_addr_lo;
        o_wdata = {2{i_data[15:0]}};
      end
      SZ_WORD: o_we = '1;
      default: o_we = '0;
    endcase
    if (o_misaligned) o_we = '0;
  end

endmodule

// File: rtl/store_data_aligner.sv
// Store buffer between MEM stage and data memory: encodes lanes, queues stores,
// and presents the head entry through registered req/ack outputs.
module store_data_aligner
  import store_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [1:0]        st_size,
  output logic              misaligned,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_we,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    lane_t             lane;
  } entry_t;

  entry_t             r_fifo [DEPTH];
  entry_t             r_head;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_req;
  logic               r_mis;

  logic [WE_W-1:0]    w_we;
  logic [DATA_W-1:0]  w_wdata;
  logic               w_mis;
  entry_t             w_new;
  entry_t             w_head_nxt;
  logic               w_full;
  logic               w_acc;
  logic               w_push;
  logic               w_pop;
  logic [CNT_W-1:0]   w_cnt_left;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [PTR_W-1:0]   w_rd_ptr_nxt;

  store_lane_encoder u_enc (
    .i_size       (st_size),
    .i_addr_lo    (st_addr[1:0]),
    .i_data       (st_data),
    .o_we         (w_we),
    .o_wdata      (w_wdata),
    .o_misaligned (w_mis)
  );

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign st_ready = !w_full && !rst;
  assign w_acc    = st_valid && st_ready;
  assign w_push   = w_acc && !w_mis;
  assign w_pop    = r_req && mem_ack;

  assign w_new.addr       = {st_addr[ADDR_W-1:2], 2'b00};
  assign w_new.lane.we    = w_we;
  assign w_new.lane.wdata = w_wdata;

  assign w_cnt_left   = r_count - CNT_W'(w_pop);
  assign w_cnt_nxt    = w_cnt_left + CNT_W'(w_push);
  assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop);
  // If nothing survives the pop, the incoming store becomes the new head directly.
  assign w_head_nxt   = (w_cnt_left == '0) ? w_new : r_fifo[w_rd_ptr_nxt];

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_new;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_req    <= 1'b0;
      r_mis    <= 1'b0;
      r_head   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_cnt_nxt;
      r_req    <= (w_cnt_nxt != '0);
      r_mis    <= w_acc && w_mis;
      // Idle keeps addr/wdata but must drop byte enables.
      if (w_cnt_nxt != '0) r_head <= w_head_nxt;
      else                 r_head.lane.we <= '0;
    end
  end

  assign mem_req    = r_req;
  assign mem_addr   = r_head.addr;
  assign mem_wdata  = r_head.lane.wdata;
  assign mem_we     = r_head.lane.we;
  assign misaligned = r_mis;
  assign empty      = (r_count == '0);

endmodule

// File: tb/tb_store_data_aligner.sv
// Directed and random stimulus for store_data_aligner, checked against a queue
// model of pending memory writes built from the size/alignment rules.
module tb_store_data_aligner;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        misaligned;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic        empty;

  always #5 clk = ~clk;

  store_data_aligner #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .misaligned(misaligned), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .empty(empty)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
  } wr_t;

  wr_t  q[$];
  logic exp_mis = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference encoding: access of 2**sz bytes, lane i carries source byte i mod size.
  function automatic void enc(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                              output logic m, output logic [3:0] we, output logic [31:0] wd);
    int nb;
    nb = 1 << sz;
    m  = (sz == 2'd3) || ((a % nb) != 0);
    we = '0;
    wd = '0;
    if (!m) begin
      we = 4'(((1 << nb) - 1) << (a % 4));
      for (int i = 0; i < 4; i++) wd[8*i +: 8] = d[8*(i % nb) +: 8];
    end
  endfunction

  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic ack, input logic r);
    logic       m;
    logic [3:0] we;
    logic [31:0] wd;
    logic       acc;
    wr_t        e;
    st_valid = v; st_addr = a; st_data = d; st_size = sz; mem_ack = ack; rst = r;
    @(negedge clk);
    chk("st_ready", st_ready, 32'(!r && (q.size() < DEPTH)));
    chk("misaligned", misaligned, 32'(exp_mis));
    chk("mem_req", mem_req, 32'(q.size() != 0));
    chk("empty", empty, 32'(q.size() == 0));
    if (q.size() != 0) begin
      chk("mem_addr", mem_addr, q[0].addr);
      chk("mem_wdata", mem_wdata, q[0].wdata);
      chk("mem_we", mem_we, 32'(q[0].we));
    end else begin
      chk("mem_we_idle", mem_we, 32'h0);
    end
    @(posedge clk);
    if (r) begin
      q.delete();
      exp_mis = 1'b0;
    end else begin
      enc(sz, a, d, m, we, wd);
      acc = v && (q.size() < DEPTH);
      if (q.size() != 0 && ack) e = q.pop_front();
      if (acc && !m) q.push_back('{a & ~32'h3, wd, we});
      exp_mis = acc && m;
    end
    #1;
  endtask

  task automatic idle(input logic ack);
    step(1'b0, 32'h0, 32'h0, 2'b00, ack, 1'b0);
  endtask

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0; mem_ack = 1'b0;
    @(posedge clk); #1;
    step(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    idle(1'b0);

    // SB to the top byte lane, ack held high
    step(1'b1, 32'h1003, 32'hDEADBEEF, 2'b00, 1'b1, 1'b0);
    chk("sb_addr", mem_addr, 32'h1000);
    chk("sb_we", mem_we, 32'h8);
    chk("sb_wdata", mem_wdata, 32'hEFEFEFEF);
    idle(1'b1);
    idle(1'b1);

    // SH with ack delayed three cycles
    step(1'b1, 32'h2002, 32'h1234ABCD, 2'b01, 1'b0, 1'b0);
    chk("sh_we", mem_we, 32'hC);
    chk("sh_wdata", mem_wdata, 32'hABCDABCD);
    for (int i = 0; i < 3; i++) idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    // Misaligned word, then illegal size
    step(1'b1, 32'h3001, 32'h11111111, 2'b10, 1'b0, 1'b0);
    chk("mis_sw", misaligned, 32'h1);
    chk("mis_sw_req", mem_req, 32'h0);
    idle(1'b0);
    step(1'b1, 32'h0, 32'h22222222, 2'b11, 1'b0, 1'b0);
    chk("mis_ill", misaligned, 32'h1);
    idle(1'b0);

    // Fill with ack low, then drain in order
    step(1'b1, 32'h10, 32'hA0A0A0A0, 2'b10, 1'b0, 1'b0);
    step(1'b1, 32'h14, 32'hB1B1B1B1, 2'b10, 1'b0, 1'b0);
    chk("full_ready", st_ready, 32'h0);
    step(1'b1, 32'h18, 32'hC2C2C2C2, 2'b10, 1'b0, 1'b0);
    step(1'b1, 32'h18, 32'hC2C2C2C2, 2'b10, 1'b1, 1'b0);
    step(1'b1, 32'h18, 32'hC2C2C2C2, 2'b10, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Streaming at one store per cycle across pointer wrap
    for (int i = 0; i < 10; i++) step(1'b1, 32'h100 + 32'(4*i), $urandom, 2'b10, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Reset while full with a request outstanding
    step(1'b1, 32'h40, 32'h5555AAAA, 2'b10, 1'b0, 1'b0);
    step(1'b1, 32'h45, 32'h0000007E, 2'b00, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b1);
    chk("rst_req", mem_req, 32'h0);
    chk("rst_empty", empty, 32'h1);
    idle(1'b1);
    idle(1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 80) == 0));
    end
    for (int i = 0; i < 4; i++) idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
